// File: rtl/rtc_ctrl_pkg.sv
// Shared types and defaults for the RTC master controller.
package rtc_ctrl_pkg;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_INIT  = 2'b01;
  localparam logic [1:0] SEL_READ  = 2'b10;
  localparam logic [1:0] SEL_WRITE = 2'b11;

  localparam int unsigned DEF_READ_PERIOD = 1000000;
  localparam int unsigned DEF_TIMEOUT     = 4096;

  // Bus-owner code for the FSM served in a given state.
  function automatic logic [1:0] sel_of(input state_t s);
    unique case (s)
      S_INIT:  return SEL_INIT;
      S_READ:  return SEL_READ;
      S_WRITE: return SEL_WRITE;
      S_IDLE:  return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Free-running period counter producing a one-cycle tick on each wrap.
module rtc_tick_gen
  import rtc_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_READ_PERIOD
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..PERIOD-1 and wrap; held at zero during reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_master_ctrl.sv
// Top-level RTC sequencer: issues active-low start requests to the init,
// read and write FSMs and selects the bus owner.
// Optional watchdog enabled by defining RTC_TIMEOUT_EN.
module rtc_master_ctrl
  import rtc_ctrl_pkg::*;
#(
  parameter int unsigned READ_PERIOD = DEF_READ_PERIOD,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_req,
  input  logic       prog_mode,
  input  logic       init_done,
  input  logic       leer_done,
  input  logic       escribir_done,
  output logic       do_it_init,
  output logic       do_it_leer,
  output logic       do_it_escribir,
  output logic [1:0] sel_fsm,
  output logic       busy,
  output logic       err_timeout
);

  state_t state, next_state;
  logic   tick;
  logic   done_cur;
  logic   timeout;
  logic   pend_rd;
  logic   pend_wr;

  rtc_tick_gen #(.PERIOD(READ_PERIOD)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifdef RTC_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wdog;

  assign timeout = busy && (wdog == WD_LAST);

  // Watchdog advances only while a request is actually driven (busy), so the
  // first S_INIT cycle after reset release counts as the init entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wdog <= '0;
    end else if (busy && (next_state == state)) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end

  // Sticky timeout flag; a done pulse on the expiry cycle takes precedence.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_timeout <= 1'b0;
    end else if (timeout && !done_cur) begin
      err_timeout <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state selection: write beats read, only the active FSM's done counts.
  always_comb begin
    next_state = state;
    done_cur   = 1'b0;
    unique case (state)
      S_INIT:  done_cur = init_done;
      S_READ:  done_cur = leer_done;
      S_WRITE: done_cur = escribir_done;
      S_IDLE: begin
        if (pend_wr) begin
          next_state = S_WRITE;
        end else if (pend_rd && !prog_mode) begin
          next_state = S_READ;
        end
      end
    endcase
    if ((state != S_IDLE) && (done_cur || timeout)) begin
      next_state = S_IDLE;
    end
  end

  // State, pending flags and outputs registered together from next_state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_INIT;
      do_it_init     <= 1'b1;
      do_it_leer     <= 1'b1;
      do_it_escribir <= 1'b1;
      sel_fsm        <= SEL_NONE;
      busy           <= 1'b0;
      pend_rd        <= 1'b0;
      pend_wr        <= 1'b0;
    end else begin
      state          <= next_state;
      do_it_init     <= (next_state != S_INIT);
      do_it_leer     <= (next_state != S_READ);
      do_it_escribir <= (next_state != S_WRITE);
      sel_fsm        <= sel_of(next_state);
      busy           <= (next_state != S_IDLE);
      // A new event on the claiming edge re-arms the flag rather than being lost.
      pend_rd <= tick | (pend_rd & ~((state == S_IDLE) && (next_state == S_READ)));
      pend_wr <= prog_req | (pend_wr & ~((state == S_IDLE) && (next_state == S_WRITE)));
    end
  end

endmodule

// File: tb/tb_rtc_master_ctrl.sv
// Self-checking bench for rtc_master_ctrl (READ_PERIOD = 50, TIMEOUT = 40).
module tb_rtc_master_ctrl;

  localparam int unsigned P = 50;
  localparam int unsigned T = 40;
`ifdef RTC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       prog_req = 1'b0;
  logic       prog_mode = 1'b0;
  logic       init_done = 1'b0;
  logic       leer_done = 1'b0;
  logic       escribir_done = 1'b0;
  logic       do_it_init, do_it_leer, do_it_escribir, busy, err_timeout;
  logic [1:0] sel_fsm;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the bus (0 none, 1 init, 2 read, 3 write),
  // edges since release, edges since the transaction began, pending requests.
  int m_cyc, m_own, m_age;
  bit m_need_init, m_pr, m_pw, m_err;

  rtc_master_ctrl #(.READ_PERIOD(P), .TIMEOUT(T)) dut (
    .clk            (clk),
    .reset          (reset),
    .prog_req       (prog_req),
    .prog_mode      (prog_mode),
    .init_done      (init_done),
    .leer_done      (leer_done),
    .escribir_done  (escribir_done),
    .do_it_init     (do_it_init),
    .do_it_leer     (do_it_leer),
    .do_it_escribir (do_it_escribir),
    .sel_fsm        (sel_fsm),
    .busy           (busy),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, pq, pm, id, ld, ed);
    bit tick, take_rd, take_wr, done_ok;
    if (!r) begin
      m_cyc = 0; m_own = 0; m_age = 0;
      m_need_init = 1'b1; m_pr = 1'b0; m_pw = 1'b0; m_err = 1'b0;
      return;
    end
    m_cyc++;
    tick    = (m_cyc % P) == 0;
    take_rd = 1'b0;
    take_wr = 1'b0;
    done_ok = (m_own == 1 && id) || (m_own == 2 && ld) || (m_own == 3 && ed);
    if (m_need_init) begin
      m_need_init = 1'b0;
      if (!id) begin
        m_own = 1; m_age = 0;
      end
    end else if (m_own != 0) begin
      m_age++;
      if (done_ok) begin
        m_own = 0;
      end else if (TO_EN && m_age == int'(T)) begin
        m_own = 0; m_err = 1'b1;
      end
    end else if (m_pw) begin
      m_own = 3; m_age = 0; take_wr = 1'b1;
    end else if (m_pr && !pm) begin
      m_own = 2; m_age = 0; take_rd = 1'b1;
    end
    m_pr = tick || (m_pr && !take_rd);
    m_pw = pq || (m_pw && !take_wr);
  endtask

  task automatic step(input logic r, pq, pm, id, ld, ed);
    @(negedge clk);
    reset = r; prog_req = pq; prog_mode = pm;
    init_done = id; leer_done = ld; escribir_done = ed;
    @(posedge clk);
    model_step(r, pq, pm, id, ld, ed);
    #1;
    check("model do_it_init", do_it_init, m_own != 1);
    check("model do_it_leer", do_it_leer, m_own != 2);
    check("model do_it_escribir", do_it_escribir, m_own != 3);
    check("model sel_fsm", sel_fsm, 32'(m_own));
    check("model busy", busy, m_own != 0);
    check("model err_timeout", err_timeout, m_err);
  endtask

  typedef struct {
    logic r, pq, id, ld, ed;
    logic e_init, e_leer, e_esc;
    logic [1:0] e_sel;
    logic e_busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int lows;
    logic r, pq, id, ld, ed;
    logic pm_state;

    // Reset, init handshake, stray dones, write request merging.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].pq, 1'b0, tbl[i].id, tbl[i].ld, tbl[i].ed);
      check($sformatf("tbl[%0d] do_it_init", i), do_it_init, tbl[i].e_init);
      check($sformatf("tbl[%0d] do_it_leer", i), do_it_leer, tbl[i].e_leer);
      check($sformatf("tbl[%0d] do_it_escribir", i), do_it_escribir, tbl[i].e_esc);
      check($sformatf("tbl[%0d] sel_fsm", i), sel_fsm, tbl[i].e_sel);
      check($sformatf("tbl[%0d] busy", i), busy, tbl[i].e_busy);
    end

    // Sequence A: init timing, tick+prog_req collision, read watchdog.
    repeat (10) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("A init req", do_it_init, 0);
    check("A init sel", sel_fsm, 2'b01);
    while (m_cyc < 19) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    check("A init exit req", do_it_init, 1);
    check("A init exit sel", sel_fsm, 2'b00);
    while (m_cyc < 49) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("A write first", sel_fsm, 2'b11);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    check("A write exit sel", sel_fsm, 2'b00);
    check("A write exit busy", busy, 0);
    step(1, 0, 0, 0, 0, 0);
    check("A read after gap", sel_fsm, 2'b10);
    while (m_cyc < 93) step(1, 0, 0, 0, 0, 0);
    check("A still reading", do_it_leer, 0);
    step(1, 0, 0, 0, 0, 0);
    check("A watchdog req", do_it_leer, TO_EN ? 1 : 0);
    check("A watchdog err", err_timeout, TO_EN);
    while (m_cyc < 100) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("A next read", do_it_leer, 0);
    step(1, 0, 0, 0, 1, 0);

    // Sequence B: prog_mode suppresses reads across two ticks, then one read.
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    lows = 0;
    while (m_cyc < 120) begin
      step(1, 0, 1, 0, 0, 0);
      if (do_it_leer !== 1'b1) lows++;
    end
    check("B suppressed reads", lows, 0);
    step(1, 0, 0, 0, 0, 0);
    check("B read after prog_mode", do_it_leer, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    lows = 0;
    while (m_cyc < 149) begin
      step(1, 0, 0, 0, 0, 0);
      if (do_it_leer !== 1'b1) lows++;
    end
    check("B single read", lows, 0);

    // Sequence C: reset in the middle of a write.
    step(1, 1, 0, 0, 0, 0);
    repeat (5) begin
      step(1, 0, 0, 0, 0, 0);
      check("C writing", do_it_escribir, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    check("C reset reqs", {do_it_init, do_it_leer, do_it_escribir}, 3'b111);
    check("C reset sel", sel_fsm, 2'b00);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("C init rerun", do_it_init, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("C no stale request", sel_fsm, 2'b00);

    // Randomized traffic against the model.
    pm_state = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 399) != 0);
      pq = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) pm_state = ~pm_state;
      id = (m_own == 1) ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 49) == 0);
      ld = (m_own == 2) ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 49) == 0);
      ed = (m_own == 3) ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 49) == 0);
      step(r, pq, pm_state, id, ld, ed);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_master_ctrl.md
Name: rtc_master_ctrl

Overview:
Top-level sequencer for the RTC controller. It sits directly upstream of the RTC read FSM, the write FSM and the init FSM, and issues their active-low do_it_* start requests. Requests come from a periodic read tick and from user programming requests. It also drives the bus-owner select that routes the active FSM's a_d/cs/rd/wr onto the RTC pins.

Parameters:
READ_PERIOD, 1000000, clock cycles between periodic read requests (10 ms at 100 MHz); minimum 2
TIMEOUT, 4096, max cycles a transaction may wait for its done pulse (RTC_TIMEOUT_EN only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
prog_req  in  1  one-cycle pulse: user requests a write of edited time/date
prog_mode  in  1  high = user editing; periodic reads suppressed
init_done  in  1  one-cycle pulse from init FSM
leer_done  in  1  one-cycle pulse from read FSM
escribir_done  in  1  one-cycle pulse from write FSM
do_it_init  out  1  active-low start request to init FSM
do_it_leer  out  1  active-low start request to read FSM
do_it_escribir  out  1  active-low start request to write FSM
sel_fsm  out  2  bus owner: 00 none, 01 init, 10 read, 11 write
busy  out  1  high while any transaction is outstanding
err_timeout  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: do_it_* = 1, sel_fsm = 00, busy = 0, err_timeout = 0, pend_rd = 0, pend_wr = 0, period counter = 0, state = S_INIT.
- States and transitions:
  - S_INIT: registered outputs do_it_init = 0, sel_fsm = 01, busy = 1 on the first clock edge after reset release. Hold until init_done = 1 is sampled, then go to S_IDLE with do_it_init = 1 on the same edge.
  - S_IDLE: all do_it_* = 1, sel_fsm = 00, busy = 0. If pend_wr, go to S_WRITE; else if pend_rd && !prog_mode, go to S_READ. Write has priority.
  - S_READ: do_it_leer = 0, sel_fsm = 10, busy = 1. pend_rd clears on entry. Exit to S_IDLE on the edge that samples leer_done = 1.
  - S_WRITE: do_it_escribir = 0, sel_fsm = 11, busy = 1. pend_wr clears on entry. Exit to S_IDLE on the edge that samples escribir_done = 1.
- Output registration: outputs are registered with the state. A request asserts on the same edge the state is entered and deasserts on the exit edge.
- Idle gap: at least one S_IDLE cycle, with all requests high, separates consecutive transactions.
- Period counter: free-runs 0..READ_PERIOD-1 in every state except reset. The wrap sets pend_rd, a sticky single-entry pending flag. Ticks while pend_rd is already set are merged.
- prog_req: sets pend_wr in any state. A second pulse while pending is merged.
- Simultaneous events:
  - Tick and prog_req in the same cycle: both flags set.
  - Tick during S_READ: a second read follows after the idle gap.
- prog_mode = 1: pend_rd may be set but is not serviced. It is serviced on the first S_IDLE cycle after prog_mode falls.
- Stray done pulses: a done pulse for a non-active FSM, or any done pulse in S_IDLE, is ignored.
- Reset mid-transaction: on the reset edge all requests go high and sel_fsm = 00. Init is re-run after release.

Optional Feature:
RTC_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entry to S_INIT, S_READ and S_WRITE and increments each cycle there.
  - When it reaches TIMEOUT-1 with no done pulse sampled: request deasserts, sel_fsm = 00, err_timeout = 1 (sticky until reset), state goes to S_IDLE.
  - Init timeout also goes to S_IDLE; init is not retried.
  - A done pulse on the timeout cycle wins and err_timeout is not set.
- Undefined: no watchdog logic, err_timeout tied to 0, waits indefinitely.

Decomposition:
- Package rtc_ctrl_pkg holds:
  - state encoding S_INIT, S_IDLE, S_READ, S_WRITE
  - sel_fsm codes SEL_NONE, SEL_INIT, SEL_READ, SEL_WRITE
  - default READ_PERIOD and TIMEOUT
- Sub-module rtc_tick_gen: parameterised period counter with a one-cycle tick output. Width is $clog2(READ_PERIOD).

Test Plan:
(All scenarios use READ_PERIOD = 50, TIMEOUT = 40, RTC_TIMEOUT_EN defined unless noted.)
1. Reset low 10 cycles, then release -> next edge do_it_init = 0, sel_fsm = 01. init_done pulse at cycle 20 -> do_it_init = 1 and sel_fsm = 00 on that edge.
2. Init done, no other input -> do_it_leer = 0 every 50 cycles. leer_done after 30 cycles -> do_it_leer = 1, busy = 0. A later tick produces the next read.
3. prog_req and tick in the same idle cycle -> S_WRITE first (sel_fsm = 11). After escribir_done and one idle cycle -> S_READ (sel_fsm = 10).
4. prog_mode = 1 across two ticks -> no do_it_leer. prog_mode falls -> exactly one read issued.
5. Read started, leer_done never returns -> after 40 cycles do_it_leer = 1, err_timeout = 1, next tick starts a read. Rebuild without RTC_TIMEOUT_EN -> do_it_leer stays 0 for 200 cycles, err_timeout = 0.
6. Reset asserted mid-write, after 5 cycles of do_it_escribir = 0 -> next edge all do_it_* = 1, sel_fsm = 00, pend flags clear. After release, init runs again.
